mmio_fb_write_buffer: RTL and testbench
=======================================

Name: mmio_fb_write_buffer

Overview:
- Sits between the CPU-side memory bus and the mmio_vga framebuffer write port.
- Decodes CPU writes that fall inside the framebuffer window (0x200–0x5FF) and queues each one as an address-offset/data pair in a FIFO.
- Drains the FIFO to the framebuffer through a valid/ready handshake, so the framebuffer can stall writes (for example during its own read slots) without losing CPU stores.
- Reports occupancy, a sticky overflow flag and a drop counter.

Parameters:
- BASE_ADDR, 16'h0200: first address of the framebuffer window (inclusive).
- LIMIT_ADDR, 16'h05FF: last address of the framebuffer window (inclusive).
- FB_AW, 10: width of the framebuffer offset address.
- DATA_W, 8: data width.
- DEPTH, 16: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clock  in  1  single system clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 resets the block; release is sampled on the clock.
- bus_addr  in  16  CPU write address.
- bus_data  in  DATA_W  CPU write data.
- bus_wr  in  1  CPU write strobe, one cycle per write.
- bus_hit  out  1  combinational: bus_wr && BASE_ADDR<=bus_addr<=LIMIT_ADDR.
- fb_addr  out  FB_AW  head entry offset, equal to bus_addr-BASE_ADDR truncated to FB_AW bits.
- fb_data  out  DATA_W  head entry data.
- fb_valid  out  1  FIFO non-empty; head entry presented.
- fb_ready  in  1  framebuffer accepts the head entry this cycle.
- level  out  log2(DEPTH)+1  current entry count, range 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- overflow  out  1  sticky; set when an in-window write is dropped.
- clr_overflow  in  1  synchronous clear of overflow and drop_count.
- drop_count  out  8  saturating count of dropped writes.

Behaviour:
- Reset (reset==0, asynchronous): read pointer, write pointer and level go to 0. Outputs take these values: fb_valid=0, fb_addr=0, fb_data=0, full=0, empty=1, overflow=0, drop_count=0. All FIFO contents are discarded. A reset in the middle of a drain aborts it with no further fb_valid.
- Decode: push = bus_hit. Writes outside the window are ignored entirely and have no effect on overflow.
- Pop: pop = fb_valid && fb_ready. fb_ready is ignored while fb_valid==0.
- Output timing: fb_addr, fb_data and fb_valid are registered from FIFO state, in first-word-fall-through style.
- Latency into an empty FIFO: a push in cycle N gives fb_valid=1 in cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO order. Successive writes to the same address are not coalesced.
- Acceptance: a push is accepted if !full, or if full && pop in the same cycle.
- Full, push and pop together: the push is accepted and level stays DEPTH.
- Drop: full && push && !pop drops the write. overflow is set to 1, drop_count increments and saturates at 255, and level is unchanged.
- Empty with push and pop together: not possible, because fb_valid==0 when empty; the push alone is taken.
- Level update: level += push_accepted - pop. full, empty and level reflect the post-edge state.
- Pointer width: pointers are log2(DEPTH) bits and wrap naturally. Level is tracked separately to distinguish full from empty.
- Head hold: when fb_valid && !fb_ready, fb_addr and fb_data hold steady until the pop.
- clr_overflow: clears overflow and drop_count next edge.
- clr_overflow coinciding with a drop: the drop wins. overflow=1 and drop_count=1.
- Throughput: one push and one pop per cycle maximum.

Test Plan:
- Reset, then bus_wr at addr 0x0200 data 0xA5 with fb_ready=1 -> fb_valid=1 one cycle later with fb_addr=0x000, fb_data=0xA5; next cycle fb_valid=0, empty=1.
- Writes at 0x01FF, 0x0200, 0x05FF and 0x0600 -> bus_hit is 0, 1, 1, 0; only offsets 0x000 and 0x3FF are queued, in that order.
- fb_ready=0 with 17 in-window writes (data 0..16) -> full=1, level=16, overflow=1, drop_count=1; after releasing fb_ready, data 0..15 drain in order and data 16 is never output.
- FIFO full with fb_ready=1 and a write every cycle for 20 cycles -> level stays 16, overflow stays 0, and the output sequence matches the input sequence.
- Toggle fb_ready every cycle while streaming 0x200..0x20F -> each fb_addr/fb_data holds while fb_ready=0, and all 16 are delivered exactly once, in order.
- Assert reset=0 mid-drain with level=8 -> immediately fb_valid=0, level=0, empty=1, overflow=0; after release, a new write appears with the correct first-entry data.

Source files
------------

// File: rtl/mmio_fb_write_buffer_if.sv
// CPU write bus and framebuffer write-port handshake for mmio_fb_write_buffer.
// The slave modport is the buffer's view; master is the CPU/framebuffer side.
interface mmio_fb_write_buffer_if #(
    parameter int FB_AW  = 10,
    parameter int DATA_W = 8
);
    logic [15:0]       bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_wr;
    logic              bus_hit;
    logic [FB_AW-1:0]  fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_valid;
    logic              fb_ready;

    modport master (
        output bus_addr, bus_data, bus_wr, fb_ready,
        input  bus_hit, fb_addr, fb_data, fb_valid
    );

    modport slave (
        input  bus_addr, bus_data, bus_wr, fb_ready,
        output bus_hit, fb_addr, fb_data, fb_valid
    );
endinterface

// File: rtl/mmio_fb_write_buffer.sv
// Queues CPU stores into the framebuffer window and drains them to the
// framebuffer write port through a first-word-fall-through valid/ready FIFO.
module mmio_fb_write_buffer #(
    parameter logic [15:0] BASE_ADDR  = 16'h0200,
    parameter logic [15:0] LIMIT_ADDR = 16'h05FF,
    parameter int          FB_AW      = 10,
    parameter int          DATA_W     = 8,
    parameter int          DEPTH      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    mmio_fb_write_buffer_if.slave    bif,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [7:0]               drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d, remaining;
    logic              fb_valid_q, fb_valid_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;

    logic [FB_AW-1:0]  mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [FB_AW-1:0]  offset;
    logic              push, pop, push_acc, drop, full_w;

    always_comb begin
        offset     = FB_AW'(bif.bus_addr - BASE_ADDR);
        push       = bif.bus_wr && (bif.bus_addr >= BASE_ADDR) && (bif.bus_addr <= LIMIT_ADDR);
        full_w     = (level_q == LVL_W'(DEPTH));
        pop        = fb_valid_q && bif.fb_ready;
        push_acc   = push && (!full_w || pop);
        drop       = push && full_w && !pop;

        wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push_acc) - LVL_W'(pop);
        remaining  = level_q - LVL_W'(pop);
        fb_valid_d = (level_d != '0);

        // Next head comes from storage if anything survives the pop,
        // otherwise straight from the store being accepted this cycle.
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (remaining != '0) begin
            fb_addr_d = mem_addr[rd_ptr_d];
            fb_data_d = mem_data[rd_ptr_d];
        end else if (push_acc) begin
            fb_addr_d = offset;
            fb_data_d = bif.bus_data;
        end

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = clr_overflow ? 8'd1
                         : (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
        end else if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            fb_valid_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            fb_valid_q   <= fb_valid_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_addr[wr_ptr_q] <= offset;
            mem_data[wr_ptr_q] <= bif.bus_data;
        end
    end

    assign bif.bus_hit  = push;
    assign bif.fb_valid = fb_valid_q;
    assign bif.fb_addr  = fb_addr_q;
    assign bif.fb_data  = fb_data_q;
    assign level        = level_q;
    assign full         = full_w;
    assign empty        = (level_q == '0);
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
endmodule

// File: tb/tb_mmio_fb_write_buffer.sv
// Directed vector table plus hand-written multi-cycle sequences for
// mmio_fb_write_buffer.
module tb_mmio_fb_write_buffer;
    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] level;
    logic       full, empty, overflow, clr_overflow;
    logic [7:0] drop_count;

    always #5 clock = ~clock;

    mmio_fb_write_buffer_if #(.FB_AW(10), .DATA_W(8)) bif ();

    mmio_fb_write_buffer #(
        .BASE_ADDR(16'h0200), .LIMIT_ADDR(16'h05FF),
        .FB_AW(10), .DATA_W(8), .DEPTH(16)
    ) dut (
        .clock(clock), .reset(reset), .bif(bif),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .clr_overflow(clr_overflow), .drop_count(drop_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic       popped;
    logic [7:0] pop_data;
    logic [9:0] pop_addr;
    logic       hit_s;

    // Called at posedge+1: drives inputs, samples combinational/handshake
    // state mid-cycle, then advances to just after the next rising edge.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic wr,
                        input logic rdy, input logic clr);
        bif.bus_addr = a;
        bif.bus_data = d;
        bif.bus_wr   = wr;
        bif.fb_ready = rdy;
        clr_overflow = clr;
        #1;
        hit_s    = bif.bus_hit;
        popped   = bif.fb_valid && bif.fb_ready;
        pop_data = bif.fb_data;
        pop_addr = bif.fb_addr;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        rdy;
        logic        exp_hit;
        logic        exp_valid;
        logic [9:0]  exp_addr;
        logic [7:0]  exp_data;
        int unsigned exp_level;
    } vec_t;

    vec_t vecs[11];
    logic [7:0] exp_q[$];

    initial begin
        vecs[0]  = '{16'h0200, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 8'hA5, 1};
        vecs[1]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 0};
        vecs[2]  = '{16'h01FF, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 0};
        vecs[3]  = '{16'h0200, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 8'h22, 1};
        vecs[4]  = '{16'h05FF, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 8'h22, 2};
        vecs[5]  = '{16'h0600, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 8'h22, 2};
        vecs[6]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FF, 8'h33, 1};
        vecs[7]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 0};
        vecs[8]  = '{16'h02AB, 8'h5C, 1'b1, 1'b1, 1'b1, 1'b1, 10'h0AB, 8'h5C, 1};
        vecs[9]  = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0AB, 8'h5C, 1};
        vecs[10] = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 0};

        reset        = 1'b0;
        bif.bus_addr = '0;
        bif.bus_data = '0;
        bif.bus_wr   = 1'b0;
        bif.fb_ready = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", bif.fb_valid, 0);
        check("rst_addr", bif.fb_addr, 0);
        check("rst_data", bif.fb_data, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", overflow, 0);
        check("rst_drops", drop_count, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rdy, 1'b0);
            check($sformatf("v%0d_hit", i), hit_s, vecs[i].exp_hit);
            check($sformatf("v%0d_valid", i), bif.fb_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_addr", i), bif.fb_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i), bif.fb_data, vecs[i].exp_data);
            end
            check($sformatf("v%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("v%0d_empty", i), empty, vecs[i].exp_level == 0);
            check($sformatf("v%0d_ovf", i), overflow, 0);
        end

        // 17 writes into a stalled FIFO: last one dropped
        for (int i = 0; i < 17; i++) step(16'(16'h0200 + i), 8'(i), 1'b1, 1'b0, 1'b0);
        check("ovfA_level", level, 16);
        check("ovfA_full", full, 1);
        check("ovfA_ovf", overflow, 1);
        check("ovfA_drops", drop_count, 1);
        begin
            int got = 0;
            for (int c = 0; c < 24; c++) begin
                step(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
                if (popped) begin
                    check("drainA_data", pop_data, got);
                    check("drainA_addr", pop_addr, got);
                    got++;
                end
            end
            check("drainA_count", got, 16);
            check("drainA_empty", empty, 1);
        end

        step(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", overflow, 0);
        check("clr_drops", drop_count, 0);

        // Clear coinciding with a drop, then saturation
        for (int i = 0; i < 16; i++) begin
            step(16'(16'h0200 + i), 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
            exp_q.push_back(8'(8'h40 + i));
        end
        step(16'h0200, 8'hEE, 1'b1, 1'b0, 1'b1);
        check("clrdrop_ovf", overflow, 1);
        check("clrdrop_drops", drop_count, 1);
        check("clrdrop_level", level, 16);
        for (int i = 0; i < 300; i++) step(16'h0210, 8'hEE, 1'b1, 1'b0, 1'b0);
        check("sat_drops", drop_count, 255);
        check("sat_level", level, 16);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        check("sat_clr_drops", drop_count, 0);
        check("sat_clr_ovf", overflow, 0);

        // Full FIFO, simultaneous push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            step(16'(16'h0200 + i), 8'(8'h80 + i), 1'b1, 1'b1, 1'b0);
            check("stream_pop", popped, 1);
            if (exp_q.size() > 0) check("stream_data", pop_data, exp_q.pop_front());
            exp_q.push_back(8'(8'h80 + i));
            check("stream_level", level, 16);
            check("stream_ovf", overflow, 0);
        end
        for (int c = 0; c < 24; c++) begin
            step(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
            if (popped) begin
                if (exp_q.size() > 0) check("streamdrain_data", pop_data, exp_q.pop_front());
                else check("streamdrain_extra", 1, 0);
            end
        end
        check("streamdrain_left", exp_q.size(), 0);
        check("streamdrain_empty", empty, 1);

        // fb_ready toggling while streaming 0x200..0x20F
        begin
            int sent = 0;
            int got = 0;
            logic       v;
            logic [9:0] a;
            logic [7:0] d;
            logic       rdy;
            for (int c = 0; c < 60 && got < 16; c++) begin
                v = bif.fb_valid;
                a = bif.fb_addr;
                d = bif.fb_data;
                rdy = (c % 2) == 1;
                step(16'(16'h0200 + sent), 8'(8'hC0 + sent), sent < 16, rdy, 1'b0);
                if (sent < 16) sent++;
                if (popped) begin
                    check("tog_addr", pop_addr, got);
                    check("tog_data", pop_data, 8'hC0 + got);
                    got++;
                end
                if (v && !rdy) begin
                    check("tog_hold_valid", bif.fb_valid, 1);
                    check("tog_hold_addr", bif.fb_addr, a);
                    check("tog_hold_data", bif.fb_data, d);
                end
            end
            check("tog_count", got, 16);
            for (int c = 0; c < 3; c++) begin
                step(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
                check("tog_no_extra", popped, 0);
            end
        end

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 10; i++) step(16'(16'h0200 + i), 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        check("mid_level", level, 8);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", bif.fb_valid, 0);
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_valid", bif.fb_valid, 0);
        step(16'h0234, 8'h9E, 1'b1, 1'b0, 1'b0);
        check("post_rst_wvalid", bif.fb_valid, 1);
        check("post_rst_addr", bif.fb_addr, 10'h034);
        check("post_rst_data", bif.fb_data, 8'h9E);
        check("post_rst_level", level, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
